// File: rtl/filtro_pkg.sv
// Shared definitions for the filtro_debounce button filter.
// Optional event counters are enabled with FILTRO_EVENTOS_EN.
package filtro_pkg;

  typedef enum logic [1:0] {
    ESTAVEL_BAIXO = 2'b00,
    SUBINDO       = 2'b01,
    ESTAVEL_ALTO  = 2'b11,
    DESCENDO      = 2'b10
  } estado_t;

  localparam int CONTAGEM_PADRAO = 50000;
  localparam int CONTAGEM_SIM    = 4;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous button levels.
// Same clock and synchronous active-low reset as its user.
module sincronizador_2ff (
  input  logic clock_filtro,
  input  logic reset,
  input  logic entrada,
  output logic saida
);

  logic sinc1;
  logic sinc2;

  always_ff @(posedge clock_filtro) begin
    if (!reset) begin
      sinc1 <= 1'b0;
      sinc2 <= 1'b0;
    end else begin
      sinc1 <= entrada;
      sinc2 <= sinc1;
    end
  end

  assign saida = sinc2;

endmodule

// File: rtl/filtro_debounce.sv
// Debounce filter: synchronizer, stability counter and 4-state FSM.
// Define FILTRO_EVENTOS_EN to add the eventos/rejeitados counters.
module filtro_debounce
  import filtro_pkg::*;
#(
  parameter int CONTAGEM = CONTAGEM_PADRAO,
  parameter int LARGURA  = 16
) (
  input  logic       clock_filtro,
  input  logic       reset,
  input  logic       clock_inicial,
`ifdef FILTRO_EVENTOS_EN
  output logic [7:0] eventos,
  output logic [7:0] rejeitados,
`endif
  output logic       clock_final,
  output logic       pulso_subida,
  output logic       pulso_descida,
  output logic       ocupado
);

  localparam logic [LARGURA-1:0] LIMITE = LARGURA'(CONTAGEM - 1);
  localparam logic [LARGURA-1:0] UM     = LARGURA'(1);

  logic               sinc2;
  estado_t            estado, estado_n;
  logic [LARGURA-1:0] contador, contador_n;
  logic               final_n;
  logic               subida_n;
  logic               descida_n;
  logic               aborto;

  sincronizador_2ff u_sinc (
    .clock_filtro (clock_filtro),
    .reset        (reset),
    .entrada      (clock_inicial),
    .saida        (sinc2)
  );

  always_comb begin
    estado_n   = estado;
    contador_n = contador;
    final_n    = clock_final;
    subida_n   = 1'b0;
    descida_n  = 1'b0;
    aborto     = 1'b0;
    unique case (estado)
      ESTAVEL_BAIXO: begin
        if (sinc2) begin
          estado_n   = SUBINDO;
          contador_n = UM;
        end else begin
          contador_n = '0;
        end
      end
      SUBINDO: begin
        if (!sinc2) begin
          estado_n   = ESTAVEL_BAIXO;
          contador_n = '0;
          aborto     = 1'b1;
        end else if (contador == LIMITE) begin
          estado_n   = ESTAVEL_ALTO;
          contador_n = '0;
          final_n    = 1'b1;
          subida_n   = 1'b1;
        end else begin
          contador_n = contador + UM;
        end
      end
      ESTAVEL_ALTO: begin
        if (!sinc2) begin
          estado_n   = DESCENDO;
          contador_n = UM;
        end else begin
          contador_n = '0;
        end
      end
      DESCENDO: begin
        if (sinc2) begin
          estado_n   = ESTAVEL_ALTO;
          contador_n = '0;
          aborto     = 1'b1;
        end else if (contador == LIMITE) begin
          estado_n   = ESTAVEL_BAIXO;
          contador_n = '0;
          final_n    = 1'b0;
          descida_n  = 1'b1;
        end else begin
          contador_n = contador + UM;
        end
      end
      default: begin
        estado_n   = ESTAVEL_BAIXO;
        contador_n = '0;
      end
    endcase
  end

  always_ff @(posedge clock_filtro) begin
    if (!reset) begin
      estado        <= ESTAVEL_BAIXO;
      contador      <= '0;
      clock_final   <= 1'b0;
      pulso_subida  <= 1'b0;
      pulso_descida <= 1'b0;
      ocupado       <= 1'b0;
    end else begin
      estado        <= estado_n;
      contador      <= contador_n;
      clock_final   <= final_n;
      pulso_subida  <= subida_n;
      pulso_descida <= descida_n;
      ocupado       <= (estado_n == SUBINDO) ||
                       (estado_n == DESCENDO);
    end
  end

`ifdef FILTRO_EVENTOS_EN
  // eventos wraps; rejeitados saturates
  always_ff @(posedge clock_filtro) begin
    if (!reset) begin
      eventos    <= 8'd0;
      rejeitados <= 8'd0;
    end else begin
      if (subida_n)
        eventos <= eventos + 8'd1;
      if (aborto && (rejeitados != 8'hFF))
        rejeitados <= rejeitados + 8'd1;
    end
  end
`endif

endmodule
